mc_ctrl: RTL and testbench
==========================

MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL have ports clk_i in 1 (sole clock, rising edge) and rst_n_i in 1 (reset); one clock; reset is asynchronous and active-low.
REQ-002 SHALL have inst_i in 32: instruction register contents; opcode [31:26], rt [20:16], funct [5:0].
REQ-003 SHALL have zero_i in 2: ALU condition result; 2'b01 = condition true.
REQ-004 SHALL have mem_ready_i in 1: memory completes the current read/write this cycle.
REQ-005 SHALL have mem_re_o out 1, mem_we_o out 1, iord_o out 1 (0 = PC address, 1 = ALUOut address).
REQ-006 SHALL have ir_we_o out 1, pc_we_o out 1, reg_we_o out 1, regdst_o out 1 (0 = rt, 1 = rd), memtoreg_o out 1.
REQ-007 SHALL have alusrca_o out 1 (0 = PC, 1 = rs), alusrcb_o out 2 (00 rt, 01 const 4, 10 sign-ext imm, 11 imm<<2), pcsrc_o out 2 (00 ALU, 01 ALUOut, 10 jump target).
REQ-008 SHALL have aluop_o out 6, using the `ALUOP_* codes from defines.v.
REQ-009 SHALL have state_o out 4, illegal_o out 1, retired_o out 32.

Function
REQ-010 SHALL be a Moore FSM: FETCH=0, DECODE=1, EXEC=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, RWB=7, BRANCH=8, JUMP=9; state_o = state; all unlisted outputs = 0.
REQ-011 FETCH: mem_re_o=1, iord_o=0, alusrca_o=0, alusrcb_o=01, aluop_o=ADD; hold while mem_ready_i=0; on mem_ready_i=1 pulse ir_we_o and pc_we_o (pcsrc 00), go DECODE.
REQ-012 DECODE: alusrca_o=0, alusrcb_o=11, aluop_o=ADD; next state by opcode: 000000 -> EXEC, I-type ALU ops -> EXEC, 100011/101011 -> MEMADR, 000001/000100-000111 -> BRANCH, 000010 -> JUMP.
REQ-013 R-type funct map: 100000/100001 ADD, 100010/100011 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 101010 SLT, 101011 SLTU, 000000 SLL, 000010 SRL, 000011 SRA, 000100 SLLV, 000110 SRLV, 000111 SRAV.
REQ-014 I-type map: 001000/001001 ADD, 001010 SLT, 001011 SLTU, 001100 AND, 001101 OR, 001110 XOR, 001111 LUI.
REQ-015 Unmapped opcode or R-type funct in DECODE: illegal_o pulses 1 cycle, next state FETCH, no register/PC/memory side effect.
REQ-016 EXEC: alusrca_o=1, alusrcb_o=00 (R-type) or 10 (I-type), aluop_o per map; next RWB.
REQ-017 RWB: reg_we_o=1, regdst_o=1 for R-type else 0, memtoreg_o=0, aluop_o held as EXEC; next FETCH.
REQ-018 MEMADR: alusrca_o=1, alusrcb_o=10, aluop_o=ADD; next MEMRD (lw) or MEMWR (sw).
REQ-019 MEMRD: mem_re_o=1, iord_o=1; hold until mem_ready_i=1, then MEMWB.
REQ-020 MEMWB: reg_we_o=1, regdst_o=0, memtoreg_o=1; next FETCH.
REQ-021 MEMWR: mem_we_o=1, iord_o=1; hold until mem_ready_i=1, then FETCH.
REQ-022 BRANCH: alusrca_o=1, alusrcb_o=00, pcsrc_o=01; aluop BEQ/BNE/BLEZ/BGTZ for 000100/000101/000110/000111; opcode 000001: rt[0]=1 BGEZ, else BLTZ; pc_we_o = (zero_i==2'b01); next FETCH.
REQ-023 JUMP: pcsrc_o=10, pc_we_o=1; next FETCH.
REQ-024 retired_o SHALL increment by 1 (wrapping at 2^32-1 -> 0) on each transition into FETCH from RWB, MEMWB, MEMWR, BRANCH or JUMP; not on illegal return.
REQ-025 Latency with mem_ready_i=1 in wait states: R/I-type 4 cycles, lw 5, sw 4, branch 3, j 3, illegal 2.
REQ-026 mem_ready_i outside FETCH/MEMRD/MEMWR SHALL be ignored.

Reset
REQ-027 rst_n_i low SHALL asynchronously force state FETCH, retired_o 0, and all outputs 0 (strobes gated) while low, including mid-transaction.
REQ-028 First rising clk_i after rst_n_i high SHALL evaluate FETCH normally.

Verification
REQ-029 Reset release, mem_ready_i=1, inst_i=0x012A4020 (add) -> states 0,1,2,7,0; RWB reg_we_o=1, regdst_o=1, aluop_o=ADD; retired_o=1.
REQ-030 inst_i=0x8D090004 (lw), mem_ready_i low 3 cycles in MEMRD -> state 4 held 4 cycles, mem_re_o=1, iord_o=1; then 5 with memtoreg_o=1.
REQ-031 inst_i=0x11090003 (beq), zero_i=01 -> BRANCH pc_we_o=1, pcsrc_o=01; repeat with zero_i=00 -> pc_we_o=0; retired_o +1 each.
REQ-032 inst_i=0xFC000000 -> DECODE then FETCH, illegal_o 1 cycle, retired_o unchanged, no strobes.
REQ-033 rst_n_i low during MEMWR with mem_we_o=1 -> mem_we_o=0 immediately, state_o=0, retired_o=0.
REQ-034 Force retired_o to 0xFFFFFFFF, complete j (0x08000010) -> retired_o=0, pcsrc_o=10 in JUMP.

Source files
------------

// File: rtl/mc_ctrl.sv
// Multicycle MIPS-style control FSM. It sequences fetch/decode/execute/memory phases,
// drives the datapath selects and write strobes, and counts retired instructions.
module mc_ctrl (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] inst_i,
    input  logic [1:0]  zero_i,
    input  logic        mem_ready_i,
    output logic        mem_re_o,
    output logic        mem_we_o,
    output logic        iord_o,
    output logic        ir_we_o,
    output logic        pc_we_o,
    output logic        reg_we_o,
    output logic        regdst_o,
    output logic        memtoreg_o,
    output logic        alusrca_o,
    output logic [1:0]  alusrcb_o,
    output logic [1:0]  pcsrc_o,
    output logic [5:0]  aluop_o,
    output logic [3:0]  state_o,
    output logic        illegal_o,
    output logic [31:0] retired_o
);
    localparam logic [5:0] ALUOP_ADD  = 6'd0;
    localparam logic [5:0] ALUOP_SUB  = 6'd1;
    localparam logic [5:0] ALUOP_AND  = 6'd2;
    localparam logic [5:0] ALUOP_OR   = 6'd3;
    localparam logic [5:0] ALUOP_XOR  = 6'd4;
    localparam logic [5:0] ALUOP_NOR  = 6'd5;
    localparam logic [5:0] ALUOP_SLT  = 6'd6;
    localparam logic [5:0] ALUOP_SLTU = 6'd7;
    localparam logic [5:0] ALUOP_SLL  = 6'd8;
    localparam logic [5:0] ALUOP_SRL  = 6'd9;
    localparam logic [5:0] ALUOP_SRA  = 6'd10;
    localparam logic [5:0] ALUOP_SLLV = 6'd11;
    localparam logic [5:0] ALUOP_SRLV = 6'd12;
    localparam logic [5:0] ALUOP_SRAV = 6'd13;
    localparam logic [5:0] ALUOP_LUI  = 6'd14;
    localparam logic [5:0] ALUOP_BEQ  = 6'd15;
    localparam logic [5:0] ALUOP_BNE  = 6'd16;
    localparam logic [5:0] ALUOP_BLEZ = 6'd17;
    localparam logic [5:0] ALUOP_BGTZ = 6'd18;
    localparam logic [5:0] ALUOP_BGEZ = 6'd19;
    localparam logic [5:0] ALUOP_BLTZ = 6'd20;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0, S_DECODE = 4'd1, S_EXEC  = 4'd2, S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4, S_MEMWB  = 4'd5, S_MEMWR = 4'd6, S_RWB    = 4'd7,
        S_BRANCH = 4'd8, S_JUMP   = 4'd9
    } state_t;

    state_t      state_q, state_d, dec_next;
    logic [5:0]  aluop_q, aluop_d, dec_aluop;
    logic        rtype_q, rtype_d, sw_q, sw_d, dec_legal;
    logic [31:0] retired_q, retired_d;
    logic [5:0]  opcode, funct;
    logic        unused_inst;

    assign opcode      = inst_i[31:26];
    assign funct       = inst_i[5:0];
    assign unused_inst = ^{inst_i[25:21], inst_i[15:6]};

    always_comb begin
        dec_aluop = ALUOP_ADD;
        dec_legal = 1'b1;
        dec_next  = S_FETCH;
        case (opcode)
            6'b000000: begin
                dec_next = S_EXEC;
                case (funct)
                    6'b100000, 6'b100001: dec_aluop = ALUOP_ADD;
                    6'b100010, 6'b100011: dec_aluop = ALUOP_SUB;
                    6'b100100: dec_aluop = ALUOP_AND;
                    6'b100101: dec_aluop = ALUOP_OR;
                    6'b100110: dec_aluop = ALUOP_XOR;
                    6'b100111: dec_aluop = ALUOP_NOR;
                    6'b101010: dec_aluop = ALUOP_SLT;
                    6'b101011: dec_aluop = ALUOP_SLTU;
                    6'b000000: dec_aluop = ALUOP_SLL;
                    6'b000010: dec_aluop = ALUOP_SRL;
                    6'b000011: dec_aluop = ALUOP_SRA;
                    6'b000100: dec_aluop = ALUOP_SLLV;
                    6'b000110: dec_aluop = ALUOP_SRLV;
                    6'b000111: dec_aluop = ALUOP_SRAV;
                    default:   dec_legal = 1'b0;
                endcase
            end
            6'b001000, 6'b001001: begin dec_next = S_EXEC; dec_aluop = ALUOP_ADD;  end
            6'b001010:            begin dec_next = S_EXEC; dec_aluop = ALUOP_SLT;  end
            6'b001011:            begin dec_next = S_EXEC; dec_aluop = ALUOP_SLTU; end
            6'b001100:            begin dec_next = S_EXEC; dec_aluop = ALUOP_AND;  end
            6'b001101:            begin dec_next = S_EXEC; dec_aluop = ALUOP_OR;   end
            6'b001110:            begin dec_next = S_EXEC; dec_aluop = ALUOP_XOR;  end
            6'b001111:            begin dec_next = S_EXEC; dec_aluop = ALUOP_LUI;  end
            6'b100011, 6'b101011: dec_next = S_MEMADR;
            6'b000001: begin
                dec_next  = S_BRANCH;
                dec_aluop = inst_i[16] ? ALUOP_BGEZ : ALUOP_BLTZ;
            end
            6'b000100: begin dec_next = S_BRANCH; dec_aluop = ALUOP_BEQ;  end
            6'b000101: begin dec_next = S_BRANCH; dec_aluop = ALUOP_BNE;  end
            6'b000110: begin dec_next = S_BRANCH; dec_aluop = ALUOP_BLEZ; end
            6'b000111: begin dec_next = S_BRANCH; dec_aluop = ALUOP_BGTZ; end
            6'b000010: dec_next = S_JUMP;
            default:   dec_legal = 1'b0;
        endcase
    end

    // Decoded fields are captured in DECODE so EXEC/RWB/BRANCH see a stable copy.
    always_comb begin
        state_d   = state_q;
        aluop_d   = aluop_q;
        rtype_d   = rtype_q;
        sw_d      = sw_q;
        retired_d = retired_q;
        case (state_q)
            S_FETCH:  if (mem_ready_i) state_d = S_DECODE;
            S_DECODE: begin
                aluop_d = dec_aluop;
                rtype_d = (opcode == 6'b000000);
                sw_d    = (opcode == 6'b101011);
                state_d = dec_legal ? dec_next : S_FETCH;
            end
            S_EXEC:   state_d = S_RWB;
            S_MEMADR: state_d = sw_q ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready_i) state_d = S_MEMWB;
            S_MEMWR:  if (mem_ready_i) state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
        if (state_d == S_FETCH && state_q != S_FETCH && state_q != S_DECODE)
            retired_d = retired_q + 32'd1;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= S_FETCH;
            aluop_q   <= ALUOP_ADD;
            rtype_q   <= 1'b0;
            sw_q      <= 1'b0;
            retired_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            aluop_q   <= aluop_d;
            rtype_q   <= rtype_d;
            sw_q      <= sw_d;
            retired_q <= retired_d;
        end
    end

    // Memory handshake: mem_re_o/mem_we_o stay high with a stable address select
    // until a cycle in which mem_ready_i is high; that cycle completes the access.
    logic       re_c, we_c, iord_c, irwe_c, pcwe_c, regwe_c, regdst_c, m2r_c, asa_c, ill_c;
    logic [1:0] asb_c, pcs_c;
    logic [5:0] aop_c;

    always_comb begin
        {re_c, we_c, iord_c, irwe_c, pcwe_c, regwe_c, regdst_c, m2r_c, asa_c, ill_c} = '0;
        asb_c = 2'b00;
        pcs_c = 2'b00;
        aop_c = ALUOP_ADD;
        case (state_q)
            S_FETCH:  begin re_c = 1'b1; asb_c = 2'b01; irwe_c = mem_ready_i; pcwe_c = mem_ready_i; end
            S_DECODE: begin asb_c = 2'b11; ill_c = ~dec_legal; end
            S_EXEC:   begin asa_c = 1'b1; asb_c = rtype_q ? 2'b00 : 2'b10; aop_c = aluop_q; end
            S_RWB:    begin regwe_c = 1'b1; regdst_c = rtype_q; aop_c = aluop_q; end
            S_MEMADR: begin asa_c = 1'b1; asb_c = 2'b10; end
            S_MEMRD:  begin re_c = 1'b1; iord_c = 1'b1; end
            S_MEMWB:  begin regwe_c = 1'b1; m2r_c = 1'b1; end
            S_MEMWR:  begin we_c = 1'b1; iord_c = 1'b1; end
            S_BRANCH: begin asa_c = 1'b1; pcs_c = 2'b01; aop_c = aluop_q; pcwe_c = (zero_i == 2'b01); end
            S_JUMP:   begin pcs_c = 2'b10; pcwe_c = 1'b1; end
            default:  ;
        endcase
    end

    // Reset gates every output immediately, even mid-transaction.
    assign mem_re_o   = rst_n_i & re_c;
    assign mem_we_o   = rst_n_i & we_c;
    assign iord_o     = rst_n_i & iord_c;
    assign ir_we_o    = rst_n_i & irwe_c;
    assign pc_we_o    = rst_n_i & pcwe_c;
    assign reg_we_o   = rst_n_i & regwe_c;
    assign regdst_o   = rst_n_i & regdst_c;
    assign memtoreg_o = rst_n_i & m2r_c;
    assign alusrca_o  = rst_n_i & asa_c;
    assign illegal_o  = rst_n_i & ill_c;
    assign alusrcb_o  = rst_n_i ? asb_c : 2'b00;
    assign pcsrc_o    = rst_n_i ? pcs_c : 2'b00;
    assign aluop_o    = rst_n_i ? aop_c : 6'd0;
    assign state_o    = state_q;
    assign retired_o  = retired_q;
endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized bench for mc_ctrl: a table-driven instruction model builds the expected
// per-cycle output trace, which is compared cycle by cycle against the controller.
module tb_mc_ctrl;
    localparam logic [5:0] A_ADD = 6'd0,  A_SUB = 6'd1,  A_AND = 6'd2,  A_OR = 6'd3,
                           A_XOR = 6'd4,  A_NOR = 6'd5,  A_SLT = 6'd6,  A_SLTU = 6'd7,
                           A_SLL = 6'd8,  A_SRL = 6'd9,  A_SRA = 6'd10, A_SLLV = 6'd11,
                           A_SRLV = 6'd12, A_SRAV = 6'd13, A_LUI = 6'd14, A_BEQ = 6'd15,
                           A_BNE = 6'd16, A_BLEZ = 6'd17, A_BGTZ = 6'd18, A_BGEZ = 6'd19,
                           A_BLTZ = 6'd20;

    typedef enum int {K_R, K_I, K_LW, K_SW, K_BR, K_J, K_ILL} kind_t;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n_i, mem_ready_i;
    logic [31:0] inst_i;
    logic [1:0]  zero_i;
    logic        mem_re_o, mem_we_o, iord_o, ir_we_o, pc_we_o, reg_we_o, regdst_o;
    logic        memtoreg_o, alusrca_o, illegal_o;
    logic [1:0]  alusrcb_o, pcsrc_o;
    logic [5:0]  aluop_o;
    logic [3:0]  state_o;
    logic [31:0] retired_o;

    mc_ctrl dut (
        .clk_i(clk), .rst_n_i(rst_n_i), .inst_i(inst_i), .zero_i(zero_i),
        .mem_ready_i(mem_ready_i), .mem_re_o(mem_re_o), .mem_we_o(mem_we_o),
        .iord_o(iord_o), .ir_we_o(ir_we_o), .pc_we_o(pc_we_o), .reg_we_o(reg_we_o),
        .regdst_o(regdst_o), .memtoreg_o(memtoreg_o), .alusrca_o(alusrca_o),
        .alusrcb_o(alusrcb_o), .pcsrc_o(pcsrc_o), .aluop_o(aluop_o), .state_o(state_o),
        .illegal_o(illegal_o), .retired_o(retired_o)
    );

    // scoreboard
    logic [23:0] exp_q[$];
    logic        rdy_q[$];
    string       tag_q[$];
    logic [31:0] exp_retired;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [5:0]  r_map[int];
    logic [5:0]  i_map[int];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [23:0] pk(input logic [3:0] st, input logic re, we, iord, irwe,
                                       pcwe, regwe, regdst, m2r, asa, input logic [1:0] asb,
                                       pcs, input logic [5:0] aop, input logic ill);
        return {st, re, we, iord, irwe, pcwe, regwe, regdst, m2r, asa, asb, pcs, aop, ill};
    endfunction

    function automatic logic [23:0] obs_vec();
        return {state_o, mem_re_o, mem_we_o, iord_o, ir_we_o, pc_we_o, reg_we_o, regdst_o,
                memtoreg_o, alusrca_o, alusrcb_o, pcsrc_o, aluop_o, illegal_o};
    endfunction

    function automatic void classify(input logic [31:0] inst, output kind_t k, output logic [5:0] aop);
        int op, fn;
        op  = int'(inst[31:26]);
        fn  = int'(inst[5:0]);
        k   = K_ILL;
        aop = A_ADD;
        if (op == 0) begin
            if (r_map.exists(fn)) begin k = K_R; aop = r_map[fn]; end
        end else if (i_map.exists(op)) begin
            k = K_I; aop = i_map[op];
        end else if (op == 35) k = K_LW;
        else if (op == 43) k = K_SW;
        else if (op == 2)  k = K_J;
        else if (op == 1) begin k = K_BR; aop = inst[16] ? A_BGEZ : A_BLTZ; end
        else if (op == 4) begin k = K_BR; aop = A_BEQ;  end
        else if (op == 5) begin k = K_BR; aop = A_BNE;  end
        else if (op == 6) begin k = K_BR; aop = A_BLEZ; end
        else if (op == 7) begin k = K_BR; aop = A_BGTZ; end
    endfunction

    task automatic push(input string tag, input logic rdy, input logic [23:0] v);
        tag_q.push_back(tag);
        rdy_q.push_back(rdy);
        exp_q.push_back(v);
    endtask

    // Expected trace of one instruction, cycle by cycle, with its mem_ready stimulus.
    task automatic build(input logic [31:0] inst, input logic [1:0] zero, input int fw, input int mw);
        kind_t      k;
        logic [5:0] aop;
        logic       rnd;
        classify(inst, k, aop);
        for (int i = 0; i < fw; i++) push("fetch_wait", 1'b0, pk(0,1,0,0,0,0,0,0,0,0,2'b01,2'b00,A_ADD,0));
        push("fetch", 1'b1, pk(0,1,0,0,1,1,0,0,0,0,2'b01,2'b00,A_ADD,0));
        rnd = 1'($urandom_range(0, 1));
        push("decode", rnd, pk(1,0,0,0,0,0,0,0,0,0,2'b11,2'b00,A_ADD,k == K_ILL));
        rnd = 1'($urandom_range(0, 1));
        case (k)
            K_R, K_I: begin
                push("exec", rnd, pk(2,0,0,0,0,0,0,0,0,1,(k == K_R) ? 2'b00 : 2'b10,2'b00,aop,0));
                rnd = 1'($urandom_range(0, 1));
                push("rwb", rnd, pk(7,0,0,0,0,0,1,k == K_R,0,0,2'b00,2'b00,aop,0));
            end
            K_LW, K_SW: begin
                push("memadr", rnd, pk(3,0,0,0,0,0,0,0,0,1,2'b10,2'b00,A_ADD,0));
                for (int i = 0; i <= mw; i++) begin
                    if (k == K_LW) push("memrd", i == mw, pk(4,1,0,1,0,0,0,0,0,0,2'b00,2'b00,A_ADD,0));
                    else           push("memwr", i == mw, pk(6,0,1,1,0,0,0,0,0,0,2'b00,2'b00,A_ADD,0));
                end
                rnd = 1'($urandom_range(0, 1));
                if (k == K_LW) push("memwb", rnd, pk(5,0,0,0,0,0,1,0,1,0,2'b00,2'b00,A_ADD,0));
            end
            K_BR: push("branch", rnd, pk(8,0,0,0,0,zero == 2'b01,0,0,0,1,2'b00,2'b01,aop,0));
            K_J:  push("jump", rnd, pk(9,0,0,0,0,1,0,0,0,0,2'b00,2'b10,A_ADD,0));
            default: ;
        endcase
        if (k != K_ILL) exp_retired = exp_retired + 32'd1;
    endtask

    // driver: one queue entry per cycle, inputs at negedge, check 1 ns later
    task automatic drain(input int n);
        for (int i = 0; i < n && exp_q.size() > 0; i++) begin
            @(negedge clk);
            mem_ready_i = rdy_q.pop_front();
            #1;
            check(tag_q.pop_front(), {8'd0, obs_vec()}, {8'd0, exp_q.pop_front()});
        end
    endtask

    task automatic idle_check();
        @(negedge clk);
        mem_ready_i = 1'b0;
        #1;
        check("idle", {8'd0, obs_vec()}, {8'd0, pk(0,1,0,0,0,0,0,0,0,0,2'b01,2'b00,A_ADD,0)});
        check("retired", retired_o, exp_retired);
    endtask

    task automatic run(input logic [31:0] inst, input logic [1:0] zero, input int fw, input int mw);
        inst_i = inst;
        zero_i = zero;
        build(inst, zero, fw, mw);
        drain(1000);
        idle_check();
    endtask

    int         bops[5] = '{1, 4, 5, 6, 7};
    logic [31:0] r, inst;
    int         sel;

    initial begin
        r_map[32] = A_ADD; r_map[33] = A_ADD; r_map[34] = A_SUB; r_map[35] = A_SUB;
        r_map[36] = A_AND; r_map[37] = A_OR;  r_map[38] = A_XOR; r_map[39] = A_NOR;
        r_map[42] = A_SLT; r_map[43] = A_SLTU; r_map[0] = A_SLL; r_map[2] = A_SRL;
        r_map[3]  = A_SRA; r_map[4] = A_SLLV; r_map[6] = A_SRLV; r_map[7] = A_SRAV;
        i_map[8]  = A_ADD; i_map[9] = A_ADD;  i_map[10] = A_SLT; i_map[11] = A_SLTU;
        i_map[12] = A_AND; i_map[13] = A_OR;  i_map[14] = A_XOR; i_map[15] = A_LUI;

        rst_n_i = 1'b0; mem_ready_i = 1'b1; inst_i = 32'd0; zero_i = 2'b00;
        exp_retired = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_outs", {8'd0, obs_vec()}, 32'd0);
        check("reset_retired", retired_o, 32'd0);
        @(negedge clk);
        mem_ready_i = 1'b0;
        rst_n_i = 1'b1;

        run(32'h012A4020, 2'b00, 0, 0);   // add
        run(32'h8D090004, 2'b00, 1, 3);   // lw with 3 wait cycles in MEMRD
        run(32'h11090003, 2'b01, 0, 0);   // beq taken
        run(32'h11090003, 2'b00, 0, 0);   // beq not taken
        run(32'hFC000000, 2'b00, 0, 0);   // illegal opcode

        for (int n = 0; n < 200; n++) begin
            r   = $urandom;
            sel = $urandom_range(0, 6);
            case (sel)
                0: inst = {6'd0, r[25:0]};
                1: inst = {3'b001, r[28:0]};
                2: inst = {6'd35, r[25:0]};
                3: inst = {6'd43, r[25:0]};
                4: inst = {6'(bops[$urandom_range(0, 4)]), r[25:0]};
                5: inst = {6'd2, r[25:0]};
                default: inst = r;
            endcase
            run(inst, 2'($urandom_range(0, 3)), $urandom_range(0, 2), $urandom_range(0, 3));
        end

        // reset asserted while a store is waiting in MEMWR
        inst_i = 32'hAD090004;
        build(inst_i, 2'b00, 0, 2);
        drain(4);
        #1;
        rst_n_i = 1'b0;
        mem_ready_i = 1'b1;
        #1;
        check("rst_mid_we", {31'd0, mem_we_o}, 32'd0);
        check("rst_mid_state", {28'd0, state_o}, 32'd0);
        check("rst_mid_outs", {8'd0, obs_vec()}, 32'd0);
        check("rst_mid_retired", retired_o, 32'd0);
        exp_q.delete(); rdy_q.delete(); tag_q.delete();
        exp_retired = 32'd0;
        @(negedge clk);
        mem_ready_i = 1'b0;
        rst_n_i = 1'b1;
        run(32'h012A4020, 2'b00, 0, 0);

        // retirement counter wrap on a jump
        inst_i = 32'h08000010;
        zero_i = 2'b00;
        build(inst_i, 2'b00, 0, 0);
        exp_retired = 32'hFFFF_FFFF;
        exp_retired = exp_retired + 32'd1;
        drain(3);
        #1;
        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
        idle_check();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
